// File: rtl/mmio_port_fifo.sv
// mmio_port_fifo: per-port TX (CPU->device) and RX (device->CPU) FIFOs behind two MMIO words.
// Define MMIO_PORT_FIFO_IRQ_EN to add a registered irq output after dev_rx_ready.
module mmio_port_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        port_inform_write,
  input  logic        port_inform_read,
  input  logic [15:0] port_data_w,
  input  logic [15:0] port_ctrl_w,
  output logic [15:0] port_data_r,
  output logic [15:0] port_status_r,
  output logic [15:0] dev_tx_data,
  output logic        dev_tx_valid,
  input  logic        dev_tx_ready,
  input  logic [15:0] dev_rx_data,
  input  logic        dev_rx_valid,
  output logic        dev_rx_ready
`ifdef MMIO_PORT_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [3:0]    tx_count_reg, rx_count_reg, tx_count_next, rx_count_next;
  logic          tx_overflow_reg, rx_underflow_reg, tx_overflow_next, rx_underflow_next;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          cpu_push, cpu_clear, tx_push, tx_drop, tx_pop, rx_push, rx_pop, rx_under;
  logic          ctrl_unused;

  assign ctrl_unused = ^port_ctrl_w[14:0];

  // Full/empty come from registered counts, so same-cycle pop never frees room for a push.
  assign tx_full  = (tx_count_reg == FULL_CNT);
  assign tx_empty = (tx_count_reg == 4'd0);
  assign rx_full  = (rx_count_reg == FULL_CNT);
  assign rx_empty = (rx_count_reg == 4'd0);

  assign cpu_push  = port_inform_write & ~port_ctrl_w[15];
  assign cpu_clear = port_inform_write &  port_ctrl_w[15];
  assign tx_push   = cpu_push & ~tx_full;
  assign tx_drop   = cpu_push &  tx_full;
  assign tx_pop    = dev_tx_valid & dev_tx_ready;
  assign rx_push   = dev_rx_valid & ~rx_full;
  assign rx_pop    = port_inform_read & ~rx_empty;
  assign rx_under  = port_inform_read &  rx_empty;

  assign dev_tx_valid  = ~tx_empty;
  assign dev_tx_data   = tx_empty ? 16'h0000 : tx_mem[tx_rd_ptr_reg];
  assign port_data_r   = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr_reg];
  assign dev_rx_ready  = ~rx_full & ~rst;
  assign port_status_r = {tx_count_reg, rx_count_reg, 2'b00, rx_underflow_reg,
                          tx_overflow_reg, rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    tx_count_next = tx_count_reg;
    rx_count_next = rx_count_reg;
    if (tx_push && !tx_pop)      tx_count_next = tx_count_reg + 4'd1;
    else if (tx_pop && !tx_push) tx_count_next = tx_count_reg - 4'd1;
    if (rx_push && !rx_pop)      rx_count_next = rx_count_reg + 4'd1;
    else if (rx_pop && !rx_push) rx_count_next = rx_count_reg - 4'd1;
    // An underflow in the same cycle as a clear still latches.
    tx_overflow_next  = (tx_overflow_reg  & ~cpu_clear) | tx_drop;
    rx_underflow_next = (rx_underflow_reg & ~cpu_clear) | rx_under;
  end

  // Storage carries no reset; stale entries are unreachable once pointers and counts clear.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= port_data_w;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= dev_rx_data;
  end

  // DEPTH is a power of two, so AW-bit pointers wrap from DEPTH-1 to 0 on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg    <= '0;
      tx_rd_ptr_reg    <= '0;
      rx_wr_ptr_reg    <= '0;
      rx_rd_ptr_reg    <= '0;
      tx_count_reg     <= 4'd0;
      rx_count_reg     <= 4'd0;
      tx_overflow_reg  <= 1'b0;
      rx_underflow_reg <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      tx_count_reg     <= tx_count_next;
      rx_count_reg     <= rx_count_next;
      tx_overflow_reg  <= tx_overflow_next;
      rx_underflow_reg <= rx_underflow_next;
    end
  end

`ifdef MMIO_PORT_FIFO_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk) begin
    if (rst) irq_reg <= 1'b0;
    else     irq_reg <= (rx_count_next != 4'd0) | tx_overflow_next | rx_underflow_next;
  end

  assign irq = irq_reg;
`endif

endmodule
